// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the RV32I pipeline slice around the ID/EX stage:
//   datapath widths, ALU op codes, branch funct3 codes and the forwarding
//   select type produced by fwd_unit and consumed by id_ex_stage.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // ALU op codes (ALUControl)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1100;

    // Branch types carried in funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Operand source select for one ALU input
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
//   Purely combinational RAW-hazard forwarding selector for the EX stage.
//   For each EX source register it picks the youngest in-flight producer:
//   MEM first, then WB, otherwise the value read in decode. x0 is never
//   forwarded since writes to it are architecturally discarded.
// Ports
//   Rs1E, Rs2E      in   EX-stage source indices
//   RdM, RegWriteM  in   MEM-stage destination and write enable
//   RdW, RegWriteW  in   WB-stage destination and write enable
//   ForwardAE/BE    out  fwd_sel_t select for rs1 / rs2 operand
// -----------------------------------------------------------------------------
module fwd_unit
    import riscv_pkg::*;
#(
    parameter int REG_AW_P = REG_AW
) (
    input  logic [REG_AW_P-1:0] Rs1E,
    input  logic [REG_AW_P-1:0] Rs2E,
    input  logic [REG_AW_P-1:0] RdM,
    input  logic                RegWriteM,
    input  logic [REG_AW_P-1:0] RdW,
    input  logic                RegWriteW,
    output fwd_sel_t            ForwardAE,
    output fwd_sel_t            ForwardBE
);

    logic w_m_ok;
    logic w_w_ok;

    assign w_m_ok = RegWriteM && (RdM != '0);
    assign w_w_ok = RegWriteW && (RdW != '0);

    always_comb begin
        ForwardAE = FWD_REG;
        if (w_m_ok && (RdM == Rs1E))      ForwardAE = FWD_M;
        else if (w_w_ok && (RdW == Rs1E)) ForwardAE = FWD_W;
    end

    always_comb begin
        ForwardBE = FWD_REG;
        if (w_m_ok && (RdM == Rs2E))      ForwardBE = FWD_M;
        else if (w_w_ok && (RdW == Rs2E)) ForwardBE = FWD_W;
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the 5-stage RV32I pipeline plus the EX-side
//   operand forwarding muxes and branch/jump target adder. Outputs feed the
//   ALU and the branch logic directly.
//   Register update priority on each rising edge: FlushE > StallE > capture.
//   A flush loads a bubble (all fields zero, ValidE=0); a stall holds.
// Configuration
//   ID_EX_FWD_EN  defined: forwarding from MEM/WB through fwd_unit.
//                 undefined: operands always come from the captured register
//                 file values and the M/W forward ports are ignored.
// Ports
//   clk, rst_n                         clock, async active-low reset
//   StallE, FlushE                     hazard-unit controls
//   *D                                 decoded inputs captured into EX
//   ALUResultM/RdM/RegWriteM           MEM-stage forward source
//   ResultW/RdW/RegWriteW              WB-stage forward source
//   SrcAE, SrcBE, WriteDataE           forwarded ALU operands / store data
//   PCTargetE, PCPlus4E                branch/jump target, link value
//   ALUControlE ... Rs2E, ValidE       registered control (ValidE=0: bubble)
// -----------------------------------------------------------------------------
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN_P   = XLEN,
    parameter int REG_AW_P = REG_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic [XLEN_P-1:0]   RD1D,
    input  logic [XLEN_P-1:0]   RD2D,
    input  logic [XLEN_P-1:0]   PCD,
    input  logic [XLEN_P-1:0]   PCPlus4D,
    input  logic [XLEN_P-1:0]   ImmExtD,
    input  logic [REG_AW_P-1:0] Rs1D,
    input  logic [REG_AW_P-1:0] Rs2D,
    input  logic [REG_AW_P-1:0] RdD,
    input  logic [3:0]          ALUControlD,
    input  logic [2:0]          funct3D,
    input  logic                ALUSrcAD,
    input  logic                ALUSrcBD,
    input  logic                RegWriteD,
    input  logic                MemWriteD,
    input  logic                BranchD,
    input  logic                JumpD,
    input  logic                JalrD,
    input  logic [1:0]          ResultSrcD,
    input  logic [XLEN_P-1:0]   ALUResultM,
    input  logic [REG_AW_P-1:0] RdM,
    input  logic                RegWriteM,
    input  logic [XLEN_P-1:0]   ResultW,
    input  logic [REG_AW_P-1:0] RdW,
    input  logic                RegWriteW,
    output logic [XLEN_P-1:0]   SrcAE,
    output logic [XLEN_P-1:0]   SrcBE,
    output logic [XLEN_P-1:0]   WriteDataE,
    output logic [XLEN_P-1:0]   PCTargetE,
    output logic [XLEN_P-1:0]   PCPlus4E,
    output logic [3:0]          ALUControlE,
    output logic [2:0]          funct3E,
    output logic                BranchE,
    output logic                JumpE,
    output logic                RegWriteE,
    output logic                MemWriteE,
    output logic [1:0]          ResultSrcE,
    output logic [REG_AW_P-1:0] RdE,
    output logic [REG_AW_P-1:0] Rs1E,
    output logic [REG_AW_P-1:0] Rs2E,
    output logic                ValidE
);

    // ID/EX registers
    logic [XLEN_P-1:0]   r_rd1, r_rd2, r_pc, r_pc4, r_imm;
    logic [REG_AW_P-1:0] r_rs1, r_rs2, r_rd;
    logic [3:0]          r_alu_ctl;
    logic [2:0]          r_funct3;
    logic                r_src_a, r_src_b;
    logic                r_reg_write, r_mem_write, r_branch, r_jump, r_jalr;
    logic [1:0]          r_result_src;
    logic                r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || FlushE) begin
            // Reset and flush both produce a fully cleared bubble.
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_pc         <= '0;
            r_pc4        <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_ctl    <= '0;
            r_funct3     <= '0;
            r_src_a      <= 1'b0;
            r_src_b      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_branch     <= 1'b0;
            r_jump       <= 1'b0;
            r_jalr       <= 1'b0;
            r_result_src <= '0;
            r_valid      <= 1'b0;
        end else if (!StallE) begin
            r_rd1        <= RD1D;
            r_rd2        <= RD2D;
            r_pc         <= PCD;
            r_pc4        <= PCPlus4D;
            r_imm        <= ImmExtD;
            r_rs1        <= Rs1D;
            r_rs2        <= Rs2D;
            r_rd         <= RdD;
            r_alu_ctl    <= ALUControlD;
            r_funct3     <= funct3D;
            r_src_a      <= ALUSrcAD;
            r_src_b      <= ALUSrcBD;
            r_reg_write  <= RegWriteD;
            r_mem_write  <= MemWriteD;
            r_branch     <= BranchD;
            r_jump       <= JumpD;
            r_jalr       <= JalrD;
            r_result_src <= ResultSrcD;
            r_valid      <= 1'b1;
        end
    end

    // Forwarding selects
    fwd_sel_t w_fwd_a_sel;
    fwd_sel_t w_fwd_b_sel;

`ifdef ID_EX_FWD_EN
    fwd_unit #(.REG_AW_P(REG_AW_P)) u_fwd (
        .Rs1E      (r_rs1),
        .Rs2E      (r_rs2),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .ForwardAE (w_fwd_a_sel),
        .ForwardBE (w_fwd_b_sel)
    );
`else
    // Hazard unit stalls for every RAW hazard, so the decode values are final.
    assign w_fwd_a_sel = FWD_REG;
    assign w_fwd_b_sel = FWD_REG;
    logic w_unused_fwd;
    assign w_unused_fwd = ^{RdM, RegWriteM, RdW, RegWriteW};
`endif

    logic [XLEN_P-1:0] w_fwd_a;
    logic [XLEN_P-1:0] w_fwd_b;

    always_comb begin
        case (w_fwd_a_sel)
            FWD_M:   w_fwd_a = ALUResultM;
            FWD_W:   w_fwd_a = ResultW;
            default: w_fwd_a = r_rd1;
        endcase
    end

    always_comb begin
        case (w_fwd_b_sel)
            FWD_M:   w_fwd_b = ALUResultM;
            FWD_W:   w_fwd_b = ResultW;
            default: w_fwd_b = r_rd2;
        endcase
    end

    // JALR target uses the forwarded rs1 and clears bit 0; branches/JAL are PC-relative.
    logic [XLEN_P-1:0] w_jalr_sum;
    assign w_jalr_sum = w_fwd_a + r_imm;

    assign SrcAE      = r_src_a ? r_pc  : w_fwd_a;
    assign SrcBE      = r_src_b ? r_imm : w_fwd_b;
    assign WriteDataE = w_fwd_b;
    assign PCTargetE  = r_jalr ? {w_jalr_sum[XLEN_P-1:1], 1'b0} : (r_pc + r_imm);
    assign PCPlus4E   = r_pc4;

    assign ALUControlE = r_alu_ctl;
    assign funct3E     = r_funct3;
    assign BranchE     = r_branch;
    assign JumpE       = r_jump;
    assign RegWriteE   = r_reg_write;
    assign MemWriteE   = r_mem_write;
    assign ResultSrcE  = r_result_src;
    assign RdE         = r_rd;
    assign Rs1E        = r_rs1;
    assign Rs2E        = r_rs2;
    assign ValidE      = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. A reference model holds the expected
//   EX-stage contents as one record, updated from the flush/stall/capture
//   rules, and derives every expected output from it. Forwarding expectations
//   follow ID_EX_FWD_EN the same way the design build does.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallE, FlushE;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [3:0]  ALUControlD;
    logic [2:0]  funct3D;
    logic        ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, BranchD, JumpD, JalrD;
    logic [1:0]  ResultSrcD;
    logic [31:0] ALUResultM, ResultW;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [31:0] SrcAE, SrcBE, WriteDataE, PCTargetE, PCPlus4E;
    logic [3:0]  ALUControlE;
    logic [2:0]  funct3E;
    logic        BranchE, JumpE, RegWriteE, MemWriteE, ValidE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  RdE, Rs1E, Rs2E;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD), .funct3D(funct3D),
        .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .JumpD(JumpD), .JalrD(JalrD), .ResultSrcD(ResultSrcD),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
        .PCPlus4E(PCPlus4E), .ALUControlE(ALUControlE), .funct3E(funct3E), .BranchE(BranchE),
        .JumpE(JumpE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .ValidE(ValidE)
    );

    always #5 clk = ~clk;

    // Reference model state: the instruction currently sitting in EX
    typedef struct {
        logic [31:0] rd1, rd2, pc, pc4, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        srca, srcb, regw, memw, br, jmp, jalr, valid;
        logic [1:0]  rsrc;
    } ex_t;

    ex_t m;
    int  n_checks = 0;
    int  n_pass   = 0;

    function automatic ex_t bubble();
        ex_t b;
        b.rd1 = 0; b.rd2 = 0; b.pc = 0; b.pc4 = 0; b.imm = 0;
        b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.alu = 0; b.f3 = 0;
        b.srca = 0; b.srcb = 0; b.regw = 0; b.memw = 0; b.br = 0;
        b.jmp = 0; b.jalr = 0; b.valid = 0; b.rsrc = 0;
        return b;
    endfunction

    function automatic ex_t from_decode();
        ex_t d;
        d.rd1 = RD1D; d.rd2 = RD2D; d.pc = PCD; d.pc4 = PCPlus4D; d.imm = ImmExtD;
        d.rs1 = Rs1D; d.rs2 = Rs2D; d.rd = RdD; d.alu = ALUControlD; d.f3 = funct3D;
        d.srca = ALUSrcAD; d.srcb = ALUSrcBD; d.regw = RegWriteD; d.memw = MemWriteD;
        d.br = BranchD; d.jmp = JumpD; d.jalr = JalrD; d.valid = 1'b1; d.rsrc = ResultSrcD;
        return d;
    endfunction

    // Value an EX source register really holds: the youngest pending write wins.
    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] regval);
`ifdef ID_EX_FWD_EN
        if (rs != 0 && RegWriteM && RdM == rs) return ALUResultM;
        if (rs != 0 && RegWriteW && RdW == rs) return ResultW;
`endif
        return regval;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_all();
        logic [31:0] fa, fb, sum;
        fa  = operand(m.rs1, m.rd1);
        fb  = operand(m.rs2, m.rd2);
        sum = fa + m.imm;
        chk("SrcAE",       SrcAE,      m.srca ? m.pc : fa);
        chk("SrcBE",       SrcBE,      m.srcb ? m.imm : fb);
        chk("WriteDataE",  WriteDataE, fb);
        chk("PCTargetE",   PCTargetE,  m.jalr ? (sum & 32'hFFFF_FFFE) : (m.pc + m.imm));
        chk("PCPlus4E",    PCPlus4E,   m.pc4);
        chk("ALUControlE", 32'(ALUControlE), 32'(m.alu));
        chk("funct3E",     32'(funct3E),     32'(m.f3));
        chk("ctrl_bits",   32'({BranchE, JumpE, RegWriteE, MemWriteE}),
                           32'({m.br, m.jmp, m.regw, m.memw}));
        chk("ResultSrcE",  32'(ResultSrcE),  32'(m.rsrc));
        chk("RdE",         32'(RdE),  32'(m.rd));
        chk("Rs1E",        32'(Rs1E), 32'(m.rs1));
        chk("Rs2E",        32'(Rs2E), 32'(m.rs2));
        chk("ValidE",      32'(ValidE), 32'(m.valid));
    endtask

    // One clock edge: DUT and model both apply flush > stall > capture.
    task automatic step();
        @(posedge clk);
        if (FlushE)       m = bubble();
        else if (!StallE) m = from_decode();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_decode();
        RD1D = $urandom; RD2D = $urandom; PCD = $urandom & 32'hFFFF_FFFC;
        PCPlus4D = PCD + 4; ImmExtD = $urandom;
        Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
        RdD = 5'($urandom_range(0, 31));
        ALUControlD = 4'($urandom); funct3D = 3'($urandom);
        ALUSrcAD = 1'($urandom); ALUSrcBD = 1'($urandom);
        RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); BranchD = 1'($urandom);
        JumpD = 1'($urandom); JalrD = 1'($urandom); ResultSrcD = 2'($urandom);
    endtask

    task automatic rand_fwd();
        ALUResultM = $urandom; ResultW = $urandom;
        RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
        RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    endtask

    task automatic clear_decode();
        RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0; ImmExtD = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0; ALUControlD = 0; funct3D = 0;
        ALUSrcAD = 0; ALUSrcBD = 0; RegWriteD = 0; MemWriteD = 0;
        BranchD = 0; JumpD = 0; JalrD = 0; ResultSrcD = 0;
        ALUResultM = 0; ResultW = 0; RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
    endtask

    initial begin
        // Reset
        rst_n = 1'b0; StallE = 0; FlushE = 0;
        clear_decode();
        m = bubble();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Random traffic to fill the stage
        for (int i = 0; i < 20; i++) begin
            rand_decode(); rand_fwd();
            step();
            check_all();
        end

        // Asynchronous reset mid-cycle clears everything at once
        StallE = 1;
        #1 rst_n = 1'b0;
        #1;
        m = bubble();
        check_all();
        chk("async_rst_valid", 32'(ValidE), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; StallE = 0;
        rand_decode();
        step();
        check_all();
        chk("post_rst_capture_rd", 32'(RdE), 32'(RdD));

        // MEM/WB priority on rs1
        clear_decode();
        Rs1D = 5; RD1D = 32'h33; RdD = 9;
        step();
        RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
        ALUResultM = 32'h11; ResultW = 32'h22;
        #1;
        check_all();
`ifdef ID_EX_FWD_EN
        chk("mw_prio_M", SrcAE, 32'h11);
        RegWriteM = 0;
        #1;
        check_all();
        chk("mw_prio_W", SrcAE, 32'h22);
`else
        chk("no_fwd_reg", SrcAE, 32'h33);
        RegWriteM = 0;
        #1;
        check_all();
        chk("no_fwd_reg2", SrcAE, 32'h33);
`endif

        // x0 is never forwarded
        clear_decode();
        step();
        RdM = 0; RegWriteM = 1; ALUResultM = 32'hDEAD;
        #1;
        check_all();
        chk("x0_srcb", SrcBE, 32'h0);
        chk("x0_wdata", WriteDataE, 32'h0);

        // Stall holds RdE=7 for 3 cycles, then flush beats stall
        clear_decode();
        RdD = 7; RegWriteD = 1;
        step();
        StallE = 1;
        for (int i = 0; i < 3; i++) begin
            RdD = 5'(10 + i);
            step();
            check_all();
            chk("stall_rd", 32'(RdE), 32'd7);
        end
        FlushE = 1;
        step();
        check_all();
        chk("flush_regw", 32'(RegWriteE), 32'd0);
        chk("flush_valid", 32'(ValidE), 32'd0);
        chk("flush_rd", 32'(RdE), 32'd0);
        FlushE = 0; StallE = 0;

        // Branch target wraps modulo 2^32; JALR clears bit 0
        clear_decode();
        PCD = 32'h100; ImmExtD = 32'hFFFF_FFF0;
        step();
        check_all();
        chk("br_target", PCTargetE, 32'h0000_00F0);
        JalrD = 1; RD1D = 32'h203; ImmExtD = 4; Rs1D = 0;
        step();
        check_all();
        chk("jalr_target", PCTargetE, 32'h206);

        // Random mix including stalls and flushes
        for (int i = 0; i < 400; i++) begin
            rand_decode(); rand_fwd();
            StallE = ($urandom_range(0, 7) == 0);
            FlushE = ($urandom_range(0, 7) == 0);
            step();
            check_all();
            rand_fwd();
            #1;
            check_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
